cmac_tx_sf_fifo: RTL

//  Store-and-forward packet FIFO on the CMAC TX user clock, directly upstream of the AXI2LBUS stream input.
//  The LBUS TX path must not see tvalid gaps inside a frame, so this block releases a frame only once it is

---
 rtl/cmac_tx_sf_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cmac_tx_sf_fifo.sv
// rtl/cmac_tx_sf_fifo.sv - store-and-forward TX packet FIFO feeding AXI2LBUS
module cmac_tx_sf_fifo #(
    parameter int TDATA_WIDTH   = 512,
    parameter int TKEEP_WIDTH   = 64,
    parameter int DEPTH         = 64,
    parameter int MAX_PKT_BEATS = 32
) (
    input  logic                     usr_tx_clk,
    input  logic                     tx_rst,
    input  logic [TDATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [TKEEP_WIDTH-1:0]   S_AXIS_tstrb,
    input  logic                     S_AXIS_tvalid,
    input  logic                     S_AXIS_tlast,
    output logic                     S_AXIS_tready,
    output logic [TDATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [TKEEP_WIDTH-1:0]   M_AXIS_tstrb,
    output logic                     M_AXIS_tvalid,
    output logic                     M_AXIS_tlast,
    input  logic                     M_AXIS_tready,
    output logic [31:0]              pkt_count,
    output logic [31:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(MAX_PKT_BEATS) + 1;
    localparam int EW = 1 + TKEEP_WIDTH + TDATA_WIDTH;

    typedef enum logic {ST_ACCEPT, ST_DROP} wr_state_t;
    typedef enum logic {ST_IDLE, ST_SEND} rd_state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] rd_data, oq0, oq1;
    logic [1:0]    oq_cnt;
    logic [PW-1:0] wr_ptr, commit_ptr, release_ptr, rd_addr, rd_ptr, level;
    logic [PW-1:0] frames_ready, frames_ready_n;
    logic [BW-1:0] beat_cnt;
    logic          commit_q, rst_done, full;
    logic          wr_en, do_commit, do_drop_start, do_drop_end;
    logic          m_pop, last_pop, rd_en;
    wr_state_t     wr_state, wr_state_n;
    rd_state_t     rd_state, rd_state_n;

    // level counts every beat not yet handed over on M_AXIS, including the output skid
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == PW'(DEPTH));
    assign fifo_level = level;
    assign rd_data    = mem[rd_addr[AW-1:0]];

    assign M_AXIS_tvalid = (oq_cnt != 2'd0);
    assign M_AXIS_tlast  = oq0[EW-1] && M_AXIS_tvalid;
    assign M_AXIS_tstrb  = oq0[EW-2 -: TKEEP_WIDTH];
    assign M_AXIS_tdata  = oq0[TDATA_WIDTH-1:0];
    assign m_pop         = M_AXIS_tvalid && M_AXIS_tready;
    assign last_pop      = m_pop && oq0[EW-1];

    always_comb begin
        wr_state_n    = wr_state;
        S_AXIS_tready = 1'b0;
        wr_en         = 1'b0;
        do_commit     = 1'b0;
        do_drop_start = 1'b0;
        do_drop_end   = 1'b0;
        case (wr_state)
            ST_ACCEPT: begin
                S_AXIS_tready = rst_done && !full;
                if (S_AXIS_tvalid && rst_done && !full) begin
                    wr_en = 1'b1;
                    if (S_AXIS_tlast) begin
                        do_commit = 1'b1;
                    end else if (beat_cnt + BW'(1) == BW'(MAX_PKT_BEATS)) begin
                        do_drop_start = 1'b1;
                        wr_state_n    = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                S_AXIS_tready = 1'b1;
                if (S_AXIS_tvalid && S_AXIS_tlast) begin
                    do_drop_end = 1'b1;
                    wr_state_n  = ST_ACCEPT;
                end
            end
        endcase
    end

    always_ff @(posedge usr_tx_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {S_AXIS_tlast, S_AXIS_tstrb, S_AXIS_tdata};
        end
    end

    always_ff @(posedge usr_tx_clk) begin
        if (tx_rst) begin
            wr_state    <= ST_ACCEPT;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            release_ptr <= '0;
            beat_cnt    <= '0;
            commit_q    <= 1'b0;
            rst_done    <= 1'b0;
            drop_count  <= '0;
        end else begin
            rst_done    <= 1'b1;
            wr_state    <= wr_state_n;
            commit_q    <= do_commit;
            release_ptr <= commit_ptr;
            if (wr_en) begin
                if (do_drop_start) begin
                    wr_ptr   <= commit_ptr;
                    beat_cnt <= '0;
                end else begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    beat_cnt <= do_commit ? '0 : beat_cnt + BW'(1);
                    if (do_commit) commit_ptr <= wr_ptr + PW'(1);
                end
            end
            if (do_drop_end) drop_count <= drop_count + 32'd1;
        end
    end

    // reads only cover released frames, so the skid never starves inside a frame
    always_comb begin
        frames_ready_n = frames_ready + PW'(commit_q) - PW'(last_pop);
        rd_state_n     = (frames_ready_n != '0) ? ST_SEND : ST_IDLE;
        rd_en          = (rd_state == ST_SEND) && (rd_addr != release_ptr) &&
                         ((oq_cnt != 2'd2) || m_pop);
    end

    always_ff @(posedge usr_tx_clk) begin
        if (tx_rst) begin
            rd_state     <= ST_IDLE;
            rd_addr      <= '0;
            rd_ptr       <= '0;
            frames_ready <= '0;
            pkt_count    <= '0;
            oq_cnt       <= 2'd0;
            oq0          <= '0;
            oq1          <= '0;
        end else begin
            rd_state     <= rd_state_n;
            frames_ready <= frames_ready_n;
            if (rd_en)    rd_addr   <= rd_addr + PW'(1);
            if (m_pop)    rd_ptr    <= rd_ptr + PW'(1);
            if (last_pop) pkt_count <= pkt_count + 32'd1;
            case (oq_cnt)
                2'd0: begin
                    if (rd_en) begin
                        oq0    <= rd_data;
                        oq_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (m_pop && rd_en) begin
                        oq0 <= rd_data;
                    end else if (m_pop) begin
                        oq_cnt <= 2'd0;
                    end else if (rd_en) begin
                        oq1    <= rd_data;
                        oq_cnt <= 2'd2;
                    end
                end
                default: begin
                    if (m_pop) begin
                        oq0 <= oq1;
                        if (rd_en) oq1    <= rd_data;
                        else       oq_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule
